// File: rtl/vga_pkg.sv
// Shared VGA timing package: nominal 640x480@60 constants,
// expected sync-edge positions and the decoder lock-state enum.
package vga_pkg;

    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FP      = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BP      = 48;
    localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FP
                                 + VGA_H_SYNC + VGA_H_BP;

    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FP      = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BP      = 33;
    localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FP
                                 + VGA_V_SYNC + VGA_V_BP;

    // Counter positions at which the falling sync edges are expected.
    localparam int VGA_H_EDGE    = VGA_H_VISIBLE + VGA_H_FP;
    localparam int VGA_V_EDGE    = VGA_V_VISIBLE + VGA_V_FP;

    localparam int VGA_LOCK_FRAMES = 2;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } lock_state_t;

endpackage

// File: rtl/vga_sync_edge.sv
// Two-flop sync sampler with falling-edge pulse.
// Ports: clk, rst (sync, active high), sync (raw input), fall (edge pulse).
module vga_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic sync,
    output logic fall
);

    logic s1;
    logic s2;

    // Reset to the idle (high) level so leaving reset cannot fake an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= sync;
            s2 <= s1;
        end
    end

    assign fall = s2 & ~s1;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers raster position from active-low hsync/vsync, checks sync
// timing, tracks lock. Ports: clk, rst, hsync, vsync in; locked, px_x,
// px_y, visible, frame_start, h_err, v_err, err_count out (all registered).
module vga_sync_decoder
    import vga_pkg::*;
#(
    parameter int H_VISIBLE   = VGA_H_VISIBLE,
    parameter int H_FP        = VGA_H_FP,
    parameter int H_SYNC      = VGA_H_SYNC,
    parameter int H_BP        = VGA_H_BP,
    parameter int V_VISIBLE   = VGA_V_VISIBLE,
    parameter int V_FP        = VGA_V_FP,
    parameter int V_SYNC      = VGA_V_SYNC,
    parameter int V_BP        = VGA_V_BP,
    parameter int LOCK_FRAMES = VGA_LOCK_FRAMES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hsync,
    input  logic       vsync,
    output logic       locked,
    output logic [9:0] px_x,
    output logic [8:0] px_y,
    output logic       visible,
    output logic       frame_start,
    output logic       h_err,
    output logic       v_err,
    output logic [7:0] err_count
);

    localparam int H_TOT    = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT    = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int H_EDGE   = H_VISIBLE + H_FP;
    localparam int V_EDGE   = V_VISIBLE + V_FP;
    localparam int TO_LIMIT = 2 * H_TOT;

    logic        h_fall;
    logic        v_fall;
    logic [9:0]  hcnt;
    logic [9:0]  vcnt;
    logic [11:0] to_cnt;

    logic        h_at_end;
    logic        v_at_end;
    logic        h_wrap;
    logic        h_err_d;
    logic        v_err_d;
    logic        any_err;
    logic        timeout;
    logic [8:0]  err_sum;

    lock_state_t state;
    logic [7:0]  good;
    logic        err_seen;

    vga_sync_edge u_h_edge (
        .clk  (clk),
        .rst  (rst),
        .sync (hsync),
        .fall (h_fall)
    );

    vga_sync_edge u_v_edge (
        .clk  (clk),
        .rst  (rst),
        .sync (vsync),
        .fall (v_fall)
    );

    // An hsync edge reloads hcnt, so the line only wraps naturally
    // when no edge is seen on the last count.
    assign h_at_end = (hcnt == 10'(H_TOT - 1));
    assign v_at_end = (vcnt == 10'(V_TOT - 1));
    assign h_wrap   = h_at_end & ~h_fall;

    assign h_err_d  = h_fall & (hcnt != 10'(H_EDGE));
    assign v_err_d  = v_fall & ((vcnt != 10'(V_EDGE)) | (hcnt != 10'd0));
    assign any_err  = h_err_d | v_err_d;

    assign timeout  = ~h_fall & (to_cnt == 12'(TO_LIMIT - 1));

    assign err_sum  = {1'b0, err_count} + 9'(h_err_d) + 9'(v_err_d);

    // Raster counters; hcnt tracks the sample currently in s1.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt   <= '0;
            vcnt   <= '0;
            to_cnt <= '0;
        end else begin
            if (h_fall) begin
                hcnt <= 10'(H_EDGE + 1);
            end else if (h_at_end) begin
                hcnt <= '0;
            end else begin
                hcnt <= hcnt + 10'd1;
            end

            if (v_fall) begin
                vcnt <= h_wrap ? 10'(V_EDGE + 1) : 10'(V_EDGE);
            end else if (h_wrap) begin
                vcnt <= v_at_end ? 10'd0 : vcnt + 10'd1;
            end

            if (h_fall || timeout) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 12'd1;
            end
        end
    end

    // Lock tracking. err_seen remembers an error inside the current
    // frame so the closing vsync edge does not count it as clean.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= SEARCH;
            good     <= '0;
            err_seen <= 1'b0;
            locked   <= 1'b0;
        end else if (timeout) begin
            state    <= SEARCH;
            good     <= '0;
            err_seen <= 1'b0;
            locked   <= 1'b0;
        end else begin
            unique case (state)
                SEARCH: begin
                    if (v_fall) begin
                        state    <= TRACK;
                        good     <= '0;
                        err_seen <= 1'b0;
                    end
                end
                TRACK: begin
                    if (v_fall) begin
                        err_seen <= 1'b0;
                        if (any_err || err_seen) begin
                            good <= '0;
                        end else if (good + 8'd1 >= 8'(LOCK_FRAMES)) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                            good   <= '0;
                        end else begin
                            good <= good + 8'd1;
                        end
                    end else if (any_err) begin
                        good     <= '0;
                        err_seen <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (any_err) begin
                        state    <= TRACK;
                        locked   <= 1'b0;
                        good     <= '0;
                        err_seen <= ~v_fall;
                    end
                end
                default: begin
                    state    <= SEARCH;
                    good     <= '0;
                    err_seen <= 1'b0;
                    locked   <= 1'b0;
                end
            endcase
        end
    end

    // Registered outputs derived from the recovered counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            px_x        <= '0;
            px_y        <= '0;
            visible     <= 1'b0;
            frame_start <= 1'b0;
            h_err       <= 1'b0;
            v_err       <= 1'b0;
            err_count   <= '0;
        end else begin
            px_x        <= (hcnt < 10'(H_VISIBLE)) ? hcnt : 10'd0;
            px_y        <= (vcnt < 10'(V_VISIBLE)) ? vcnt[9:1] : 9'd0;
            visible     <= locked
                         & (hcnt < 10'(H_VISIBLE))
                         & (vcnt < 10'(V_VISIBLE));
            frame_start <= locked & (hcnt == 10'd0) & (vcnt == 10'd0);
            h_err       <= h_err_d;
            v_err       <= v_err_d;
            err_count   <= err_sum[8] ? 8'hFF : err_sum[7:0];
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Self-checking bench for vga_sync_decoder on a reduced raster
// (32x18 totals) driven by an in-bench sync generator.
module tb_vga_sync_decoder;

    localparam int HV    = 16;
    localparam int HFP   = 4;
    localparam int HS    = 6;
    localparam int HB    = 6;
    localparam int HT    = HV + HFP + HS + HB;
    localparam int VV    = 10;
    localparam int VFP   = 2;
    localparam int VS    = 2;
    localparam int VB    = 4;
    localparam int VT    = VV + VFP + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int HE    = HV + HFP;
    localparam int VE    = VV + VFP;
    localparam int LOCKF = 2;
    localparam int GL_H  = 5;
    localparam int GL_V  = 4;

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        logic       vis;
        logic       fs;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       hsync;
    logic       vsync;
    logic       locked;
    logic [9:0] px_x;
    logic [8:0] px_y;
    logic       visible;
    logic       frame_start;
    logic       h_err;
    logic       v_err;
    logic [7:0] err_count;

    exp_t sb_q[$];
    int   pos;
    int   cyc;
    int   checks;
    int   errors;
    bit   sb_en;
    bit   h_hold;
    bit   gl_en;
    bit   gl_every;
    bit   vd_en;

    vga_sync_decoder #(
        .H_VISIBLE   (HV),
        .H_FP        (HFP),
        .H_SYNC      (HS),
        .H_BP        (HB),
        .V_VISIBLE   (VV),
        .V_FP        (VFP),
        .V_SYNC      (VS),
        .V_BP        (VB),
        .LOCK_FRAMES (LOCKF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .hsync       (hsync),
        .vsync       (vsync),
        .locked      (locked),
        .px_x        (px_x),
        .px_y        (px_y),
        .visible     (visible),
        .frame_start (frame_start),
        .h_err       (h_err),
        .v_err       (v_err),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    function automatic exp_t exp_of(input int p);
        exp_t e;
        int   h;
        int   v;
        h     = p % HT;
        v     = p / HT;
        e.x   = (h < HV) ? 10'(h) : 10'd0;
        e.y   = (v < VV) ? 9'(v / 2) : 9'd0;
        e.vis = (h < HV) && (v < VV);
        e.fs  = (p == 0);
        return e;
    endfunction

    task automatic drive();
        int h;
        int v;
        bit vlow;
        h     = pos % HT;
        v     = pos / HT;
        hsync = !((h >= HE) && (h < HE + HS));
        if (gl_en && h >= GL_H && h < GL_H + 3 && (gl_every || v == GL_V))
            hsync = 1'b0;
        if (h_hold)
            hsync = 1'b1;
        if (vd_en)
            vlow = (v > VE) && (v <= VE + VS);
        else
            vlow = (v >= VE) && (v < VE + VS);
        vsync = !vlow;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        pos = (pos == FRAME - 1) ? 0 : pos + 1;
        drive();
        if (sb_en)
            sb_q.push_back(exp_of(pos));
    endtask

    task automatic wait_pos(input int p);
        for (int i = 0; i < FRAME + 1; i++) begin
            if (pos == p)
                break;
            step();
        end
    endtask

    task automatic wait_lock(input int budget, output int took);
        took = -1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (locked === 1'b1) begin
                took = i + 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        hsync    = 1'b1;
        vsync    = 1'b1;
        h_hold   = 0;
        gl_en    = 0;
        gl_every = 0;
        vd_en    = 0;
        sb_en    = 0;
        pos      = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            checks++;
            if ({locked, px_x, px_y, visible, frame_start,
                 h_err, v_err, err_count} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: got %0h/%0h/%0h/%0b/%0b/%0b/%0b/%0h want all 0",
                         locked, px_x, px_y, visible, frame_start,
                         h_err, v_err, err_count);
            end
        end
        rst = 1'b0;
        pos = 1;
        cyc = 0;
        drive();
    endtask

    task automatic test_nominal();
        int   took;
        exp_t e;
        bit   any_e;
        wait_lock(3 * FRAME, took);
        checks++;
        if (cyc !== VE * HT + 2 * FRAME + 1) begin
            errors++;
            $display("FAIL lock_latency: got cycle %0d want %0d",
                     cyc, VE * HT + 2 * FRAME + 1);
        end
        checks++;
        if (err_count !== 8'd0) begin
            errors++;
            $display("FAIL nominal_err_count: got %0d want 0", err_count);
        end
        sb_q.delete();
        sb_en = 1;
        any_e = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            if (h_err || v_err)
                any_e = 1;
            if (sb_q.size() == 3) begin
                e = sb_q.pop_front();
                checks++;
                if ({px_x, px_y, visible, frame_start} !== e) begin
                    errors++;
                    $display("FAIL nominal_px: got x=%0d y=%0d vis=%0b fs=%0b want x=%0d y=%0d vis=%0b fs=%0b",
                             px_x, px_y, visible, frame_start,
                             e.x, e.y, e.vis, e.fs);
                end
            end
        end
        sb_en = 0;
        sb_q.delete();
        checks++;
        if (any_e) begin
            errors++;
            $display("FAIL nominal_no_pulse: got err pulse want none");
        end
        wait_pos(2 * HT + 5);
        step();
        step();
        checks++;
        if (px_y !== 9'd1 || px_x !== 10'd5 || visible !== 1'b1) begin
            errors++;
            $display("FAIL line2_py: got y=%0d x=%0d vis=%0b want y=1 x=5 vis=1",
                     px_y, px_x, visible);
        end
        checks++;
        if (locked !== 1'b1 || err_count !== 8'd0) begin
            errors++;
            $display("FAIL nominal_lock: got locked=%0b cnt=%0d want 1/0",
                     locked, err_count);
        end
    endtask

    task automatic test_hsync_glitch();
        int took;
        bit seen;
        wait_pos(0);
        gl_every = 0;
        gl_en    = 1;
        seen     = 0;
        for (int i = 0; i < FRAME; i++) begin
            step();
            if (h_err === 1'b1 && !seen) begin
                seen = 1;
                checks++;
                if (locked !== 1'b0) begin
                    errors++;
                    $display("FAIL glitch_unlock: got locked=%0b want 0", locked);
                end
                checks++;
                if (err_count !== 8'd1) begin
                    errors++;
                    $display("FAIL glitch_count: got %0d want 1", err_count);
                end
            end
        end
        gl_en = 0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL glitch_h_err: got no h_err want pulse");
        end
        wait_lock(4 * FRAME, took);
        checks++;
        if (took < 0) begin
            errors++;
            $display("FAIL glitch_relock: got locked=%0b want 1", locked);
        end
    endtask

    task automatic test_late_vsync();
        int took;
        bit seen;
        wait_pos(0);
        vd_en = 1;
        seen  = 0;
        for (int i = 0; i < FRAME; i++) begin
            step();
            if (v_err === 1'b1 && !seen) begin
                seen = 1;
                checks++;
                if (locked !== 1'b0) begin
                    errors++;
                    $display("FAIL late_unlock: got locked=%0b want 0", locked);
                end
            end
        end
        vd_en = 0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL late_v_err: got no v_err want pulse");
        end
        // vcnt was reloaded one line behind the generator.
        wait_pos(2 * HT + 5);
        step();
        step();
        checks++;
        if (px_y !== 9'd0 || px_x !== 10'd5) begin
            errors++;
            $display("FAIL late_realign: got y=%0d x=%0d want y=0 x=5",
                     px_y, px_x);
        end
        wait_lock(4 * FRAME, took);
        checks++;
        if (took < 0) begin
            errors++;
            $display("FAIL late_relock: got locked=%0b want 1", locked);
        end
    endtask

    task automatic test_sync_loss();
        int took;
        wait_pos(0);
        h_hold = 1;
        repeat (100) step();
        checks++;
        if (locked !== 1'b0 || visible !== 1'b0) begin
            errors++;
            $display("FAIL loss_search: got locked=%0b vis=%0b want 0/0",
                     locked, visible);
        end
        h_hold = 0;
        wait_lock(4 * FRAME, took);
        checks++;
        if (took < 0) begin
            errors++;
            $display("FAIL loss_relock: got locked=%0b want 1", locked);
        end
    endtask

    task automatic test_saturation();
        bit   mono;
        logic [7:0] last;
        wait_pos(0);
        gl_every = 1;
        gl_en    = 1;
        mono     = 1;
        last     = err_count;
        for (int i = 0; i < 300 * HT; i++) begin
            step();
            if (err_count < last)
                mono = 0;
            last = err_count;
        end
        gl_en    = 0;
        gl_every = 0;
        checks++;
        if (err_count !== 8'd255) begin
            errors++;
            $display("FAIL sat_value: got %0d want 255", err_count);
        end
        checks++;
        if (!mono) begin
            errors++;
            $display("FAIL sat_monotonic: got decrease want non-decreasing");
        end
        repeat (8 * HT) step();
        checks++;
        if (err_count !== 8'd255) begin
            errors++;
            $display("FAIL sat_hold: got %0d want 255", err_count);
        end
    endtask

    task automatic test_mid_reset();
        int took;
        wait_lock(5 * FRAME, took);
        checks++;
        if (took < 0) begin
            errors++;
            $display("FAIL pre_reset_lock: got locked=%0b want 1", locked);
        end
        wait_pos(6 * HT + 3);
        rst = 1'b1;
        repeat (3) begin
            step();
            checks++;
            if ({locked, px_x, px_y, visible, frame_start,
                 h_err, v_err, err_count} !== '0) begin
                errors++;
                $display("FAIL mid_reset: got %0h/%0h/%0h/%0b/%0b/%0b/%0b/%0h want all 0",
                         locked, px_x, px_y, visible, frame_start,
                         h_err, v_err, err_count);
            end
        end
        rst = 1'b0;
        wait_lock(3 * FRAME, took);
        checks++;
        if (took < 0) begin
            errors++;
            $display("FAIL reset_relock: got locked=%0b want 1", locked);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        test_reset();
        test_nominal();
        test_hsync_glitch();
        test_late_vsync();
        test_sync_loss();
        test_saturation();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
